// File: rtl/tachyon_irq_pkg.sv
// tachyon_irq_pkg: register map, CTRL bit and source indices shared by the interrupt controller.
package tachyon_irq_pkg;

    typedef enum logic [2:0] {
        IRQ_REG_PENDING      = 3'd0,
        IRQ_REG_ENABLE       = 3'd1,
        IRQ_REG_TIMER_RELOAD = 3'd2,
        IRQ_REG_TIMER_COUNT  = 3'd3,
        IRQ_REG_CTRL         = 3'd4
    } irq_reg_e;

    localparam int IRQ_CTRL_TEN = 0;

    localparam int IRQ_SRC_VBLANK = 0;
    localparam int IRQ_SRC_TIMER  = 1;
    localparam int IRQ_SRC_JOYPAD = 2;
    localparam int IRQ_SRC_AUDIO  = 3;

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/irq_timer.sv
// irq_timer: 32-bit periodic down-counter with byte-lane reload/ctrl writes and a one-cycle event.
module irq_timer
    import tachyon_irq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wdata,
    input  logic [31:0] bmask,
    input  logic        we_reload,
    input  logic        we_ctrl,
    output logic [31:0] reload,
    output logic [31:0] count,
    output logic        ten,
    output logic        evt
);

    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic        ten_q, ten_d;

    // A reload write restarts the period from the merged value; enabling restarts from reload.
    always_comb begin
        reload_d = we_reload ? (reload_q & ~bmask) | (wdata & bmask) : reload_q;
        ten_d    = (we_ctrl && bmask[IRQ_CTRL_TEN]) ? wdata[IRQ_CTRL_TEN] : ten_q;
        evt      = ten_q && (count_q == '0);
        count_d  = we_reload ? reload_d :
                   !ten_q    ? (ten_d ? reload_q : count_q) :
                   evt       ? reload_q : count_q - 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            count_q  <= '0;
            ten_q    <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            ten_q    <= ten_d;
        end
    end

    assign reload = reload_q;
    assign count  = count_q;
    assign ten    = ten_q;

endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-detects peripheral events into pending bits, masks by enable, drives irq.
// Define IRQ_CTRL_SYNC_EN to pass each external source through a 2-flop synchroniser first.
module irq_controller
    import tachyon_irq_pkg::*;
#(
    parameter int               N_SRC       = 4,
    parameter int               TIMER_SRC   = IRQ_SRC_TIMER,
    parameter logic [N_SRC-1:0] SRC_ACT_LOW = 4'b0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wenable,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] src_in,
    output logic             irq
);

    irq_reg_e         sel;
    logic [31:0]      bmask;
    logic [N_SRC-1:0] norm, evt, w1c;
    logic [N_SRC-1:0] samp_q, samp_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] en_q, en_d;
    logic [31:0]      reload, count;
    logic             ten, tmr_evt;
    logic             unused_addr;

    assign sel         = irq_reg_e'(addr[4:2]);
    assign bmask       = lane_mask(wenable);
    assign unused_addr = ^addr[1:0];

`ifdef IRQ_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    assign sync1_d = src_in ^ SRC_ACT_LOW;
    assign sync2_d = sync1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign norm = sync2_q;
`else
    assign norm = src_in ^ SRC_ACT_LOW;
`endif

    irq_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wdata     (wdata),
        .bmask     (bmask),
        .we_reload (sel == IRQ_REG_TIMER_RELOAD && |wenable),
        .we_ctrl   (sel == IRQ_REG_CTRL),
        .reload    (reload),
        .count     (count),
        .ten       (ten),
        .evt       (tmr_evt)
    );

    // The timer already produces a pulse, so it bypasses edge detection; new events beat W1C.
    always_comb begin
        samp_d         = norm;
        evt            = norm & ~samp_q;
        evt[TIMER_SRC] = tmr_evt;
        w1c            = (sel == IRQ_REG_PENDING) ? wdata[N_SRC-1:0] & bmask[N_SRC-1:0] : '0;
        pend_d         = (pend_q & ~w1c) | evt;
        en_d           = (sel == IRQ_REG_ENABLE) ?
                         (en_q & ~bmask[N_SRC-1:0]) | (wdata[N_SRC-1:0] & bmask[N_SRC-1:0]) : en_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            pend_q <= '0;
            en_q   <= '0;
        end else begin
            samp_q <= samp_d;
            pend_q <= pend_d;
            en_q   <= en_d;
        end
    end

    assign rdata = sel == IRQ_REG_PENDING      ? 32'(pend_q) :
                   sel == IRQ_REG_ENABLE       ? 32'(en_q)   :
                   sel == IRQ_REG_TIMER_RELOAD ? reload      :
                   sel == IRQ_REG_TIMER_COUNT  ? count       :
                   sel == IRQ_REG_CTRL         ? {31'd0, ten} : '0;

    assign irq = |(pend_q & en_q);

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_irq_controller;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif
    localparam logic [3:0] ACT_LOW = 4'b0001;
    localparam int TSRC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wenable = '0;
    logic [31:0] rdata;
    logic [3:0]  src_in = 4'b0001;
    logic        irq;
    logic        run = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    irq_controller #(.N_SRC(4), .TIMER_SRC(TSRC), .SRC_ACT_LOW(ACT_LOW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .wdata   (wdata),
        .wenable (wenable),
        .rdata   (rdata),
        .src_in  (src_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference state: the timer is tracked as cycles elapsed since the last (re)load.
    logic [3:0]  m_pend, m_en;
    logic [31:0] m_rel;
    logic        m_ten;
    longint      m_el;
    logic [3:0]  hist[$];

    function automatic logic [31:0] lanes(input logic [3:0] w);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{w[b]}};
        return m;
    endfunction

    function automatic logic [31:0] cur_count();
        longint r;
        r = {32'd0, m_rel};
        return 32'(r - (m_el % (r + 1)));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {28'd0, m_pend};
            3'd1:    return {28'd0, m_en};
            3'd2:    return m_rel;
            3'd3:    return cur_count();
            3'd4:    return {31'd0, m_ten};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] bm, wv;
        logic [3:0]  ev;
        logic        rw, cw;
        int          s;
        if (!rst_n) begin
            m_pend = '0; m_en = '0; m_rel = '0; m_ten = 1'b0; m_el = 0;
            hist.delete();
            for (int i = 0; i < L; i++) hist.push_back(4'd0);
        end else begin
            bm = lanes(wenable);
            wv = wdata & bm;
            hist.push_back(src_in ^ ACT_LOW);
            s = hist.size();
            ev = hist[s-L] & ~hist[s-L-1];
            void'(hist.pop_front());
            ev[TSRC] = m_ten && cur_count() == 0;
            rw = addr[4:2] == 3'd2 && wenable != 0;
            cw = addr[4:2] == 3'd4 && wenable[0];
            if (addr[4:2] == 3'd0) m_pend = m_pend & ~wv[3:0];
            if (addr[4:2] == 3'd1) m_en = (m_en & ~bm[3:0]) | wv[3:0];
            if (rw) begin
                m_rel = (m_rel & ~bm) | wv;
                m_el = 0;
            end else if (m_ten) m_el++;
            if (cw) begin
                if (!m_ten && wdata[0]) m_el = 0;
                m_ten = wdata[0];
            end
            m_pend = m_pend | ev;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        check("cyc_rdata", rdata, m_read(addr));
        check("cyc_irq", {31'd0, irq}, {31'd0, |(m_pend & m_en)});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] we);
        addr = a; wdata = d; wenable = we;
        tick(1);
        wenable = '0;
    endtask

    task automatic chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(nm, rdata, exp);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        #1;
        check(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        run = 1'b1;
        chk("rst_pending", 5'd0, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // vblank is active-low: a falling v_sync is the event
        wr(5'd4, 32'd1, 4'b0001);
        src_in[0] = 1'b0;
        tick(L - 1);
        chk_irq("vblank_irq_early", 1'b0);
        tick(1);
        chk_irq("vblank_irq", 1'b1);
        chk("vblank_pending", 5'd0, 32'd1);
        src_in[0] = 1'b1;
        tick(L + 1);
        chk("vblank_no_rise_event", 5'd0, 32'd1);
        wr(5'd0, 32'd1, 4'b0001);
        chk("vblank_w1c", 5'd0, 32'd0);
        chk_irq("vblank_irq_clr", 1'b0);

        wr(5'd8, 32'hAABBCCDD, 4'b0010);
        chk("lane_reload", 5'd8, 32'h0000CC00);
        chk("lane_count", 5'd12, 32'h0000CC00);

        wr(5'd20, 32'hFFFFFFFF, 4'b1111);
        chk("unmapped_read", 5'd20, 32'd0);
        chk("unmapped_no_effect", 5'd4, 32'd1);

        wr(5'd8, 32'd9, 4'b1111);
        wr(5'd4, 32'd2, 4'b0001);
        wr(5'd16, 32'd1, 4'b0001);
        chk("timer_ctrl", 5'd16, 32'd1);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("timer_count_%0d", k), 5'd12, 32'(9 - k % 10));
            if (k == 9) chk("timer_pend_before_wrap", 5'd0, 32'd0);
            tick(1);
        end
        chk("timer_pending", 5'd0, 32'd2);
        wr(5'd16, 32'd0, 4'b0001);
        wr(5'd0, 32'd2, 4'b0001);
        chk("timer_stop_count", 5'd12, 32'd8);

        src_in[2] = 1'b1;
        tick(L - 1);
        wr(5'd0, 32'd4, 4'b0001);
        chk("collision_set_wins", 5'd0, 32'd4);
        src_in[2] = 1'b0;

        chk_irq("mask_off_irq", 1'b0);
        wr(5'd4, 32'd0, 4'b0001);
        chk_irq("mask_zero_irq", 1'b0);
        wr(5'd4, 32'd4, 4'b0001);
        chk_irq("mask_on_irq", 1'b1);
        wr(5'd4, 32'd0, 4'b0001);
        chk_irq("mask_drop_irq", 1'b0);
        chk("mask_keeps_pending", 5'd0, 32'd4);

        wr(5'd8, 32'd0, 4'b1111);
        wr(5'd16, 32'd1, 4'b0001);
        tick(2);
        chk("reload0_pending", 5'd0, 32'd6);
        wr(5'd0, 32'd2, 4'b0001);
        chk("reload0_sticky", 5'd0, 32'd6);

        src_in = 4'b1000;
        tick(L);
        chk("all_pending", 5'd0, 32'hF);
        wr(5'd4, 32'hF, 4'b0001);
        chk_irq("all_irq", 1'b1);
        rst_n = 1'b0;
        chk_irq("async_rst_irq", 1'b0);
        chk("async_rst_pending", 5'd0, 32'd0);
        chk("async_rst_enable", 5'd4, 32'd0);
        chk("async_rst_reload", 5'd8, 32'd0);
        chk("async_rst_ctrl", 5'd16, 32'd0);
        src_in = 4'b1001;
        tick(2);
        rst_n = 1'b1;
        chk("release_pending", 5'd0, 32'd0);
        tick(L);
        chk("release_high_src_event", 5'd0, 32'd8);
        tick(3);
        chk("release_timer_off", 5'd12, 32'd0);
        chk_irq("release_irq", 1'b0);

        tick(2);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
